vga_timing_pipe: RTL
====================

Name: vga_timing_pipe

Overview:
- Parametrised successor to the fixed 640x480 VGA controller plus RGB output buffer used in the game top level.
- Generates pixel tick, x/y coordinates, sync and blanking for any resolution and porch set.
- Accepts RGB from a pixel generator with a known fixed latency, delays sync/blank to match, and registers all pin outputs together.
- Adds frame_start/line_start strobes for game-logic timing.

Parameters:
CLK_DIV, 4, system clocks per pixel; legal values are 1 and up.
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch in pixels
H_SYNC, 96, horizontal sync width in pixels
H_BP, 48, horizontal back porch in pixels
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vertical sync width in lines
V_BP, 33, vertical back porch in lines
HSYNC_POL, 0, active level of hsync
VSYNC_POL, 0, active level of vsync
COLOR_BITS, 4, bits per colour channel
PIPE_STAGES, 2, pixel-generator latency in p_ticks; 0 is legal.
CW, 10, coordinate width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL).

Ports:
clk_100MHz  in  1  system clock
reset  in  1  synchronous, active-low reset
rgb_in  in  3*COLOR_BITS  pixel colour for the coordinate issued PIPE_STAGES ticks earlier
p_tick  out  1  one-clock pixel enable
x  out  CW  current horizontal count
y  out  CW  current vertical count
video_on  out  1  undelayed active-area flag, aligned with x/y
line_start  out  1  one-clock pulse
frame_start  out  1  one-clock pulse
hsync  out  1  registered horizontal sync, pipeline-aligned
vsync  out  1  registered vertical sync, pipeline-aligned
rgb  out  3*COLOR_BITS  registered colour; zero outside the active area

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (reset==0 at a clock edge) returns everything on that edge, including mid-frame:
  - div_cnt=0, h_cnt=0, v_cnt=0.
  - Pipeline delay registers cleared to the inactive/blank state.
  - rgb=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
  - p_tick, line_start, frame_start forced to 0 while reset is low.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - p_tick = (div_cnt==CLK_DIV-1) combinational, gated by reset.
  - CLK_DIV=1 means p_tick is high every cycle out of reset.
  - With CLK_DIV=4, the first p_tick is on the 4th clock after reset release.
- Counters advance only on p_tick:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 at V_TOTAL-1 on the same tick as the h wrap.
  - x=h_cnt, y=v_cnt.
- Raw signals, combinational from the counters:
  - video_on = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
  - hs_raw active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw active on the same rule using the V parameters.
  - Active means equal to *_POL.
- Strobes:
  - line_start = p_tick && h_cnt==H_TOTAL-1.
  - frame_start = line_start && v_cnt==V_TOTAL-1.
  - Both mark the tick on which the counters enter (0,·) and (0,0).
- Alignment pipeline:
  - A PIPE_STAGES-deep shift register of {video_on, hs_raw, vs_raw}, shifting only on p_tick.
- Output register, updated only on p_tick:
  - rgb <= delayed video_on ? rgb_in : 0.
  - hsync/vsync <= delayed raw values.
  - Outputs hold between ticks.
- Latency: coordinate to pin is PIPE_STAGES+1 p_ticks for colour and sync alike.
- rgb_in is sampled only on p_tick; changes between ticks are ignored.

Test Plan:
- Defaults; release reset, count clocks to each p_tick -> first p_tick on clock 4, then every 4 clocks; x steps 0,1,2,… per tick.
- Run one full frame -> exactly 800*525 p_ticks between frame_start pulses; 525 line_start pulses; x max 799, y max 524.
- Sync timing -> hsync low for exactly 96 ticks, starting when the pixel generator sees x=656, delayed 3 ticks at the pin; vsync low for lines 490–491 (delayed).
- Drive rgb_in=12'hFFF always -> rgb is 12'hFFF only for the 640x480 active window shifted 3 ticks, 12'h000 elsewhere.
- Drive rgb_in={x[3:0],y[3:0],4'h5} delayed by 2 ticks in the bench, with PIPE_STAGES=2 -> at the pin the colour matches the delayed coordinate every active pixel. Repeat with PIPE_STAGES=0 and CLK_DIV=1.
- Assert reset at x=300, y=200 for one clock -> on that edge the counters read (0,0), rgb=0, hsync=vsync=1 (POL=0), no strobes; the next frame_start comes after a full 800*525 ticks.

Source files
------------

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA timing generator with a pixel-clock divider and a colour/sync
// alignment pipeline, so rgb, hsync and vsync reach the pins on the same pixel tick.
module vga_timing_pipe #(
    parameter int CLK_DIV     = 4,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit HSYNC_POL   = 1'b0,
    parameter bit VSYNC_POL   = 1'b0,
    parameter int COLOR_BITS  = 4,
    parameter int PIPE_STAGES = 2,
    parameter int CW          = 10
) (
    input  logic                    clk_100MHz,
    input  logic                    reset,
    input  logic [3*COLOR_BITS-1:0] rgb_in,
    output logic                    p_tick,
    output logic [CW-1:0]           x,
    output logic [CW-1:0]           y,
    output logic                    video_on,
    output logic                    line_start,
    output logic                    frame_start,
    output logic                    hsync,
    output logic                    vsync,
    output logic [3*COLOR_BITS-1:0] rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CB      = 3 * COLOR_BITS;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    // {video_on, hsync, vsync} as seen outside the visible area
    localparam logic [2:0]    CTL_IDLE = {1'b0, ~HSYNC_POL, ~VSYNC_POL};

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic          p_tick_s, line_start_s, video_on_s, hs_raw_s, vs_raw_s;
    logic [2:0]    ctl_raw_s, ctl_dly_s;
    logic [CB-1:0] rgb_q, rgb_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;

    // Divider and counter next-state
    always_comb begin
        div_cnt_d = div_cnt_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
        if (p_tick_s) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end else begin
            h_cnt_d = h_cnt_q;
            v_cnt_d = v_cnt_q;
        end
    end

    // Divider and coordinate counter state
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            div_cnt_q <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
        end
    end

    assign p_tick_s     = reset & (div_cnt_q == DIV_LAST);
    assign line_start_s = p_tick_s & (h_cnt_q == H_LAST);
    assign video_on_s   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign hs_raw_s     = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    assign vs_raw_s     = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    assign ctl_raw_s    = {video_on_s, hs_raw_s, vs_raw_s};

    generate
        if (PIPE_STAGES == 0) begin : g_no_pipe
            assign ctl_dly_s = ctl_raw_s;
        end else begin : g_pipe
            logic [2:0] pipe_q [PIPE_STAGES];

            // Delay line matching the pixel generator latency
            always_ff @(posedge clk_100MHz) begin
                if (!reset) begin
                    for (int i = 0; i < PIPE_STAGES; i++) begin
                        pipe_q[i] <= CTL_IDLE;
                    end
                end else if (p_tick_s) begin
                    pipe_q[0] <= ctl_raw_s;
                    for (int i = 1; i < PIPE_STAGES; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign ctl_dly_s = pipe_q[PIPE_STAGES-1];
        end
    endgenerate

    // Pin register next-state: colour blanked outside the delayed active area
    always_comb begin
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (p_tick_s) begin
            rgb_d   = ctl_dly_s[2] ? rgb_in : '0;
            hsync_d = ctl_dly_s[1];
            vsync_d = ctl_dly_s[0];
        end else begin
            rgb_d   = rgb_q;
            hsync_d = hsync_q;
            vsync_d = vsync_q;
        end
    end

    // Pin register state
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            rgb_q   <= '0;
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign p_tick      = p_tick_s;
    assign x           = h_cnt_q;
    assign y           = v_cnt_q;
    assign video_on    = video_on_s;
    assign line_start  = line_start_s;
    assign frame_start = line_start_s & (v_cnt_q == V_LAST);
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;

endmodule
